fp_compare_issue: RTL and testbench

Issue and response stage that wraps a fixed-latency floating-point less-than comparator. It accepts compare/min/max requests on a valid/ready interface and drives the comparator operands. It tracks request metadata alongside the comparator pipeline and buffers results in a small FIFO, giving downstream consumers full backpressure. Credit-based admission guarantees that a result arriving from the comparator always has a FIFO slot, because the comparator itself cannot stall.

---
 rtl/fp_cmp_pkg.sv | 36 +++
 rtl/fp_resp_fifo.sv | 49 ++++
 rtl/fp_compare_issue.sv | 100 ++++++++++
 tb/tb_fp_compare_issue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cmp_pkg.sv
// Shared op encoding, metadata/result records and result-formation helper
// for the floating-point compare issue stage.
package fp_cmp_pkg;

  localparam int FP_CMP_TAG_WIDTH = 8;

  localparam logic [1:0] FP_CMP_LT  = 2'b00;
  localparam logic [1:0] FP_CMP_GT  = 2'b01;
  localparam logic [1:0] FP_CMP_MIN = 2'b10;
  localparam logic [1:0] FP_CMP_MAX = 2'b11;

  typedef struct packed {
    logic [1:0]                  op;
    logic [31:0]                 a;
    logic [31:0]                 b;
    logic [FP_CMP_TAG_WIDTH-1:0] tag;
  } fp_cmp_meta_t;

  typedef struct packed {
    logic [31:0]                 data;
    logic [FP_CMP_TAG_WIDTH-1:0] tag;
  } fp_cmp_res_t;

  // GT already had its operands swapped at issue, so it reads cmp_lt like LT.
  function automatic fp_cmp_res_t fp_cmp_form(input fp_cmp_meta_t m, input logic lt);
    fp_cmp_res_t r;
    r.tag = m.tag;
    case (m.op)
      FP_CMP_MIN: r.data = lt ? m.a : m.b;
      FP_CMP_MAX: r.data = lt ? m.b : m.a;
      default:    r.data = {31'b0, lt};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fp_resp_fifo.sv
// Synchronous result FIFO with registered full/empty derived from wrap-bit
// pointers. A write while full is accepted only alongside a pop.
module fp_resp_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic             full;
  logic             do_wr, do_rd;

  assign do_rd    = rd_en && !empty;
  assign do_wr    = wr_en && (!full || do_rd);
  assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, do_wr};
  assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, do_rd};
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      empty  <= (wr_ptr_n == rd_ptr_n);
      full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
    end
  end

  // When full, the write slot equals the slot being popped this cycle.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fp_compare_issue.sv
// Issue/response stage around an external fixed-latency FP less-than unit:
// operand steering, metadata pipeline, credit-limited admission, result FIFO.
module fp_compare_issue
  import fp_cmp_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int TAG_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic [31:0]          cmp_a,
  output logic [31:0]          cmp_b,
  input  logic                 cmp_lt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (TAG_WIDTH != FP_CMP_TAG_WIDTH) begin : g_bad_tag
    $error("fp_compare_issue: TAG_WIDTH must equal FP_CMP_TAG_WIDTH");
  end
  if (DEPTH < LATENCY + 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fp_compare_issue: DEPTH must be a power of two >= LATENCY+2");
  end

  logic              accept, pop;
  logic [CW-1:0]     inflight;
  logic              fifo_empty;
  logic [LATENCY-1:0] pipe_vld;
  fp_cmp_meta_t      pipe_meta [LATENCY];
  fp_cmp_meta_t      in_meta;
  fp_cmp_res_t       res_in, res_out;

  assign in_ready = !areset && (inflight < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // The comparator always computes cmp_a < cmp_b, so GT swaps the operands.
  assign cmp_a = (in_op == FP_CMP_GT) ? in_b : in_a;
  assign cmp_b = (in_op == FP_CMP_GT) ? in_a : in_b;

  assign in_meta = '{op: in_op, a: in_a, b: in_b, tag: in_tag};

  always_ff @(posedge clk) begin
    if (areset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pipe_meta[0] <= in_meta;
    for (int i = 1; i < LATENCY; i++) pipe_meta[i] <= pipe_meta[i-1];
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      inflight <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign res_in = fp_cmp_form(pipe_meta[LATENCY-1], cmp_lt);

  fp_resp_fifo #(
    .WIDTH($bits(fp_cmp_res_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .areset  (areset),
    .wr_en   (pipe_vld[LATENCY-1]),
    .wr_data (res_in),
    .rd_en   (out_ready),
    .rd_data (res_out),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = res_out.data;
  assign out_tag   = res_out.tag;

endmodule

// File: tb/tb_fp_compare_issue.sv
// Bench for fp_compare_issue: models the external comparator, predicts results
// from the op rules, and scoreboards responses in acceptance order.
module tb_fp_compare_issue;

  localparam int LATENCY = 2;
  localparam int TAG_W   = 8;
  localparam int DEPTH   = 4;

  logic              clk = 1'b0;
  logic              areset;
  logic              in_valid, in_ready;
  logic [1:0]        in_op;
  logic [31:0]       in_a, in_b;
  logic [TAG_W-1:0]  in_tag;
  logic [31:0]       cmp_a, cmp_b;
  logic              cmp_lt;
  logic              out_valid, out_ready;
  logic [31:0]       out_data;
  logic [TAG_W-1:0]  out_tag;

  fp_compare_issue #(.LATENCY(LATENCY), .TAG_WIDTH(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .areset(areset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_lt(cmp_lt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // IEEE-754 single less-than: NaN unordered, +0 == -0.
  function automatic bit fp_lt(input logic [31:0] a, input logic [31:0] b);
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 1'b0;
    if (a[30:0] == 0 && b[30:0] == 0) return 1'b0;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  function automatic logic [31:0] exp_data(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return {31'b0, fp_lt(a, b)};
      2'd1:    return {31'b0, fp_lt(b, a)};
      2'd2:    return fp_lt(a, b) ? a : b;
      default: return fp_lt(a, b) ? b : a;
    endcase
  endfunction

  // External comparator: fixed LATENCY-cycle delay line.
  logic [31:0] dl_a [LATENCY];
  logic [31:0] dl_b [LATENCY];
  always @(posedge clk) begin
    dl_a[0] <= cmp_a;
    dl_b[0] <= cmp_b;
    for (int i = 1; i < LATENCY; i++) begin
      dl_a[i] <= dl_a[i-1];
      dl_b[i] <= dl_b[i-1];
    end
  end
  assign cmp_lt = fp_lt(dl_a[LATENCY-1], dl_b[LATENCY-1]);

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             exp_q [$];
  int               pop_cyc_q [$];
  int               n_chk = 0;
  int               n_err = 0;
  int               cyc = 0;
  bit               acc_s, pop_s;
  logic [31:0]      pop_data;
  logic [TAG_W-1:0] pop_tag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called just after a falling edge with inputs set; samples the handshake
  // that the next rising edge will commit, then advances one cycle.
  task automatic step();
    exp_t e;
    #1;
    acc_s = 0;
    pop_s = 0;
    if (areset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        pop_s    = 1;
        pop_data = out_data;
        pop_tag  = out_tag;
        pop_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("stale_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data", out_data, e.data);
          check("tag", out_tag, e.tag);
        end
      end
      if (in_valid && in_ready) begin
        acc_s  = 1;
        e.data = exp_data(in_op, in_a, in_b);
        e.tag  = in_tag;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
    in_valid = 1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_one(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag,
                          input logic [31:0] expd);
    int lat;
    bit got;
    out_ready = 1;
    set_req(op, a, b, tag);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = acc_s;
    end
    in_valid = 0;
    check({nm, "_accept"}, got, 1);
    lat = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      lat++;
      got = pop_s;
    end
    check({nm, "_latency"}, lat, LATENCY + 1);
    check({nm, "_data"}, pop_data, expd);
    check({nm, "_tag"}, pop_tag, tag);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FC0_0000;
      3: return 32'h3F80_0000;
      4: return 32'hBF80_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    int idx, stall, p0, tagc;
    areset    = 1;
    in_valid  = 1;
    in_op     = 2'd0;
    in_a      = 32'h3F80_0000;
    in_b      = 32'h4000_0000;
    in_tag    = 8'hEE;
    out_ready = 1;
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    areset   = 0;
    in_valid = 0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    send_one("lt", 2'd0, 32'h3F80_0000, 32'h4000_0000, 8'h11, 32'd1);
    idle(2);
    send_one("gt", 2'd1, 32'h3F80_0000, 32'h4000_0000, 8'h12, 32'd0);
    idle(2);
    send_one("min", 2'd2, 32'hC040_0000, 32'h3F00_0000, 8'h13, 32'hC040_0000);
    idle(2);
    send_one("max", 2'd3, 32'hC040_0000, 32'h3F00_0000, 8'h14, 32'h3F00_0000);
    idle(2);

    // Backpressure: only DEPTH requests admitted while the consumer stalls.
    out_ready = 0;
    idx = 0;
    p0  = pop_cyc_q.size();
    for (int i = 0; i < 10; i++) begin
      set_req(2'(idx), 32'h4000_0000 + idx, 32'h4000_0002, 8'h20 + 8'(idx));
      step();
      if (acc_s) idx++;
    end
    check("bp_accepted", idx, DEPTH);
    check("bp_in_ready", in_ready, 0);
    out_ready = 1;
    for (int i = 0; i < 30 && idx < 6; i++) begin
      set_req(2'(idx), 32'h4000_0000 + idx, 32'h4000_0002, 8'h20 + 8'(idx));
      step();
      if (acc_s) idx++;
    end
    check("bp_all_accepted", idx, 6);
    idle(10);
    check("bp_pops", pop_cyc_q.size() - p0, 6);

    // Streaming: back-to-back with no stalls either side.
    pop_cyc_q.delete();
    idx   = 0;
    stall = 0;
    for (int i = 0; i < 40 && idx < 16; i++) begin
      set_req(2'($urandom_range(0, 3)), pick(), pick(), 8'h40 + 8'(idx));
      step();
      if (acc_s) idx++;
      else stall++;
    end
    idle(8);
    check("stream_accepted", idx, 16);
    check("stream_stalls", stall, 0);
    check("stream_pops", pop_cyc_q.size(), 16);
    if (pop_cyc_q.size() == 16)
      check("stream_consecutive", pop_cyc_q[15] - pop_cyc_q[0], 15);

    // Reset with one result queued and two still in the comparator.
    out_ready = 0;
    set_req(2'd0, 32'h3F80_0000, 32'h4000_0000, 8'h60);
    step();
    idle(4);
    set_req(2'd2, 32'h3F80_0000, 32'h4000_0000, 8'h61);
    step();
    set_req(2'd3, 32'h3F80_0000, 32'h4000_0000, 8'h62);
    step();
    in_valid = 0;
    areset   = 1;
    step();
    areset = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    out_ready = 1;
    p0 = pop_cyc_q.size();
    idle(8);
    check("midrst_no_stale", pop_cyc_q.size() - p0, 0);
    send_one("after_rst", 2'd3, 32'hC040_0000, 32'h3F00_0000, 8'h63, 32'h3F00_0000);

    // Random traffic with random consumer backpressure.
    tagc = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_a      = pick();
      in_b      = ($urandom_range(0, 5) == 0) ? in_a : pick();
      in_tag    = 8'(tagc);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      if (acc_s) tagc++;
    end
    out_ready = 1;
    idle(20);
    check("drain_empty", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
